// File: rtl/manchester_rx_pkg.sv
// rtl/manchester_rx_pkg.sv - shared types and constants for the Manchester frame receiver
//
// Purpose: FSM state encoding, Manchester chip-pair codes, CRC-8 constants and
//          small decode/CRC helper functions used by manchester_frame_rx and crc8_serial.
// Ports:   none (package).

package manchester_rx_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_TAIL    = 2'd2
    } rx_state_e;

    localparam logic [1:0] MAN_ONE  = 2'b10;
    localparam logic [1:0] MAN_ZERO = 2'b01;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    function automatic logic man_valid(input logic [1:0] pair);
        return (pair == MAN_ONE) || (pair == MAN_ZERO);
    endfunction

    // One MSB-first step of the CRC-8 shift register.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// rtl/crc8_serial.sv - bit-serial CRC-8 accumulator
//
// Purpose: accumulates CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR)
//          one bit per enabled cycle, MSB-first.
// Ports:   clk, rst_n (async active-low), clr (reload init, wins over en),
//          en (consume din this cycle), din (data bit), crc (current remainder).

module crc8_serial
    import manchester_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = CRC8_INIT;
        end else if (en) begin
            crc_d = crc8_step(crc_q, din);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC8_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/manchester_frame_rx.sv
// rtl/manchester_frame_rx.sv - parametrised Manchester frame receiver with output handshake
//
// Purpose: hunts for a HEAD chip pattern, decodes 8*NBYTES Manchester bits,
//          checks a TAIL chip pattern and hands good frames to the consumer
//          through a valid/ready output register.
// Config:  RX_CRC8_EN - when defined, the last payload byte is checked as a
//          CRC-8 of the preceding bytes and crc_err is added to the ports.
// Ports:   clk, rst_n (async active-low); bin/ben chip value and strobe;
//          payload/frame_vld/frame_rdy output handshake (byte 0 in the MSBs);
//          sym_err, tail_err, overrun (and crc_err) one-cycle error pulses.

module manchester_frame_rx
    import manchester_rx_pkg::*;
#(
    parameter int                HEAD_W = 4,
    parameter logic [HEAD_W-1:0] HEAD   = 4'b1100,
    parameter int                TAIL_W = 4,
    parameter logic [TAIL_W-1:0] TAIL   = 4'b0011,
    parameter int                NBYTES = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bin,
    input  logic                ben,
    output logic [8*NBYTES-1:0] payload,
    output logic                frame_vld,
    input  logic                frame_rdy,
    output logic                sym_err,
    output logic                tail_err,
    output logic                overrun
`ifdef RX_CRC8_EN
    ,
    output logic                crc_err
`endif
);

    localparam int PAY_BITS  = 8 * NBYTES;
    localparam int PAY_CHIPS = 16 * NBYTES;
    localparam int CNT_W     = $clog2(PAY_CHIPS + TAIL_W + 1);

    localparam logic [CNT_W-1:0] LAST_PAY  = CNT_W'(PAY_CHIPS - 1);
    localparam logic [CNT_W-1:0] LAST_TAIL = CNT_W'(TAIL_W - 1);

    rx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [HEAD_W-1:0]     hunt_q, hunt_d;
    logic [TAIL_W-1:0]     tail_q, tail_d;
    logic                  first_q, first_d;
    logic [PAY_BITS-1:0]   work_q, work_d;
    logic [PAY_BITS-1:0]   payload_q, payload_d;
    logic                  vld_q, vld_d;
    logic                  sym_err_q, sym_err_d;
    logic                  tail_err_q, tail_err_d;
    logic                  overrun_q, overrun_d;

    // Shift registers viewed with the current chip already shifted in, so the
    // header/trailer compare happens on the same strobe that completes it.
    logic [HEAD_W-1:0] hunt_shift;
    logic [TAIL_W-1:0] tail_shift;
    logic [1:0]        pair;
    logic              hunt_match;
    logic              pair_done;
    logic              tail_done;
    logic              frame_good;
    logic              crc_ok;

    assign hunt_shift = HEAD_W'({hunt_q, bin});
    assign tail_shift = TAIL_W'({tail_q, bin});
    assign pair       = {first_q, bin};
    assign hunt_match = (hunt_shift == HEAD);
    assign pair_done  = ben && (state_q == ST_PAYLOAD) && cnt_q[0];
    assign tail_done  = ben && (state_q == ST_TAIL) && (cnt_q == LAST_TAIL);
    assign frame_good = tail_done && (tail_shift == TAIL);

`ifdef RX_CRC8_EN
    localparam logic [CNT_W-1:0] CRC_CHIPS = CNT_W'(16 * (NBYTES - 1));

    logic       crc_clr;
    logic       crc_en;
    logic [7:0] crc;
    logic       crc_err_q, crc_err_d;

    // For a valid pair the decoded bit equals its first chip.
    assign crc_clr = ben && (state_q == ST_HUNT) && hunt_match;
    assign crc_en  = pair_done && (cnt_q < CRC_CHIPS);

    crc8_serial u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (crc_clr),
        .en    (crc_en),
        .din   (first_q),
        .crc   (crc)
    );

    assign crc_ok = (crc == work_q[7:0]);
`else
    assign crc_ok = 1'b1;
`endif

    // State register (and all other flops).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HUNT;
            cnt_q      <= '0;
            hunt_q     <= '0;
            tail_q     <= '0;
            first_q    <= 1'b0;
            work_q     <= '0;
            payload_q  <= '0;
            vld_q      <= 1'b0;
            sym_err_q  <= 1'b0;
            tail_err_q <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef RX_CRC8_EN
            crc_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hunt_q     <= hunt_d;
            tail_q     <= tail_d;
            first_q    <= first_d;
            work_q     <= work_d;
            payload_q  <= payload_d;
            vld_q      <= vld_d;
            sym_err_q  <= sym_err_d;
            tail_err_q <= tail_err_d;
            overrun_q  <= overrun_d;
`ifdef RX_CRC8_EN
            crc_err_q  <= crc_err_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (ben) begin
            case (state_q)
                ST_HUNT: begin
                    if (hunt_match) state_d = ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    if (cnt_q[0]) begin
                        if (!man_valid(pair))     state_d = ST_HUNT;
                        else if (cnt_q == LAST_PAY) state_d = ST_TAIL;
                    end
                end
                ST_TAIL: begin
                    if (cnt_q == LAST_TAIL) state_d = ST_HUNT;
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // Datapath and output logic.
    always_comb begin
        cnt_d      = cnt_q;
        hunt_d     = hunt_q;
        tail_d     = tail_q;
        first_d    = first_q;
        work_d     = work_q;
        sym_err_d  = 1'b0;
        tail_err_d = 1'b0;
        overrun_d  = 1'b0;
        payload_d  = payload_q;
        vld_d      = vld_q && !frame_rdy;
`ifdef RX_CRC8_EN
        crc_err_d  = 1'b0;
`endif

        if (ben) begin
            case (state_q)
                ST_HUNT: begin
                    hunt_d = hunt_shift;
                    if (hunt_match) begin
                        // Frames never overlap: the next hunt starts from scratch.
                        hunt_d = '0;
                        cnt_d  = '0;
                    end
                end
                ST_PAYLOAD: begin
                    cnt_d = cnt_q + 1'b1;
                    if (!cnt_q[0]) begin
                        first_d = bin;
                    end else if (!man_valid(pair)) begin
                        sym_err_d = 1'b1;
                        cnt_d     = '0;
                        hunt_d    = '0;
                    end else begin
                        work_d = {work_q[PAY_BITS-2:0], pair == MAN_ONE};
                        if (cnt_q == LAST_PAY) cnt_d = '0;
                    end
                end
                ST_TAIL: begin
                    tail_d = tail_shift;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_TAIL) begin
                        cnt_d  = '0;
                        hunt_d = '0;
                    end
                end
                default: begin
                    cnt_d  = '0;
                    hunt_d = '0;
                end
            endcase
        end

        if (tail_done && !frame_good) tail_err_d = 1'b1;

`ifdef RX_CRC8_EN
        if (frame_good && !crc_ok) crc_err_d = 1'b1;
`endif

        // A finished frame may load when the register is empty or is being
        // drained on this same edge; otherwise it is dropped and reported.
        if (frame_good && crc_ok) begin
            if (!vld_q || frame_rdy) begin
                payload_d = work_q;
                vld_d     = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign payload   = payload_q;
    assign frame_vld = vld_q;
    assign sym_err   = sym_err_q;
    assign tail_err  = tail_err_q;
    assign overrun   = overrun_q;
`ifdef RX_CRC8_EN
    assign crc_err   = crc_err_q;
`endif

endmodule

// File: tb/tb_manchester_frame_rx.sv
// tb/tb_manchester_frame_rx.sv - self-checking bench for manchester_frame_rx (default parameters)

module tb_manchester_frame_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bin = 1'b0;
    logic        ben = 1'b0;
    logic        frame_rdy = 1'b1;
    logic [39:0] payload;
    logic        frame_vld;
    logic        sym_err;
    logic        tail_err;
    logic        overrun;
`ifdef RX_CRC8_EN
    logic        crc_err;
`endif

    always #5 clk = ~clk;

    manchester_frame_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bin       (bin),
        .ben       (ben),
        .payload   (payload),
        .frame_vld (frame_vld),
        .frame_rdy (frame_rdy),
        .sym_err   (sym_err),
        .tail_err  (tail_err),
        .overrun   (overrun)
`ifdef RX_CRC8_EN
        ,
        .crc_err   (crc_err)
`endif
    );

    typedef struct {
        logic [39:0] data;
        int          gap;
        int          kind;      // 0 good, 1 invalid pair in byte 2, 2 bad trailer
        logic        exp_vld;
        int          exp_sym;
        int          exp_tail;
    } vec_t;

    int          n_run = 0;
    int          n_fail = 0;
    int          sym_cnt = 0;
    int          tail_cnt = 0;
    int          ovr_cnt = 0;
    int          crc_cnt = 0;
    logic [39:0] sb[$];
    logic        chips[$];
    vec_t        vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pulse counters and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (sym_err)  sym_cnt++;
        if (tail_err) tail_cnt++;
        if (overrun)  ovr_cnt++;
`ifdef RX_CRC8_EN
        if (crc_err)  crc_cnt++;
`endif
        if (frame_vld && frame_rdy) begin
            if (sb.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL sb_unexpected: frame %h delivered, none expected", payload);
            end else begin
                check("sb_payload", 64'(payload), 64'(sb.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

`ifdef RX_CRC8_EN
    function automatic logic [7:0] crc8_model(input logic [31:0] m);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 0; k < 4; k++) begin
            c = c ^ m[31-8*k -: 8];
            for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
`endif

    function automatic logic [39:0] with_crc(input logic [39:0] d);
`ifdef RX_CRC8_EN
        return {d[39:8], crc8_model(d[39:8])};
`else
        return d;
`endif
    endfunction

    task automatic build(input logic [39:0] d, input int kind);
        logic [3:0] hd;
        logic [3:0] tl;
        hd = 4'b1100;
        tl = (kind == 2) ? 4'b0111 : 4'b0011;
        chips.delete();
        for (int i = 3; i >= 0; i--) chips.push_back(hd[i]);
        for (int b = 39; b >= 0; b--) begin
            if (kind == 1 && b == 20) begin
                chips.push_back(1'b1);
                chips.push_back(1'b1);
                return;
            end
            chips.push_back(d[b]);
            chips.push_back(!d[b]);
        end
        for (int i = 3; i >= 0; i--) chips.push_back(tl[i]);
    endtask

    // Called and returns at 1 time unit after a rising edge.
    task automatic send_chip(input logic b, input int gap);
        ben = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bin = b;
        ben = 1'b1;
        @(posedge clk);
        #1;
        ben = 1'b0;
    endtask

    task automatic send_all_but_last(input int gap);
        for (int j = 0; j < chips.size() - 1; j++) send_chip(chips[j], gap);
    endtask

    task automatic clear_counts();
        sym_cnt = 0;
        tail_cnt = 0;
        ovr_cnt = 0;
        crc_cnt = 0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [39:0] fa, fb, fc, fd, ff;

    initial begin
        vecs[0] = '{40'h123456789A, 0, 0, 1'b1, 0, 0};
        vecs[1] = '{40'h123456789A, 2, 0, 1'b1, 0, 0};
        vecs[2] = '{40'hA5C3F0E19B, 0, 1, 1'b0, 1, 0};
        vecs[3] = '{40'h00FF55AA01, 0, 0, 1'b1, 0, 0};
        vecs[4] = '{40'h0F1E2D3C4B, 1, 2, 1'b0, 0, 1};
        vecs[5] = '{40'hDEADBEEF42, 1, 0, 1'b1, 0, 0};
        vecs[6] = '{40'hFFFFFFFFFF, 0, 0, 1'b1, 0, 0};
        vecs[7] = '{40'h0000000000, 0, 0, 1'b1, 0, 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_payload",  64'(payload),   64'h0);
        check("rst_vld",      64'(frame_vld), 64'h0);
        check("rst_sym_err",  64'(sym_err),   64'h0);
        check("rst_tail_err", 64'(tail_err),  64'h0);
        check("rst_overrun",  64'(overrun),   64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven frames, consumer always ready
        frame_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [39:0] d;
            d = (vecs[i].kind == 0) ? with_crc(vecs[i].data) : vecs[i].data;
            clear_counts();
            build(d, vecs[i].kind);
            send_all_but_last(vecs[i].gap);
            check($sformatf("v%0d_pre_vld", i), 64'(frame_vld), 64'h0);
            if (vecs[i].exp_vld) sb.push_back(d);
            send_chip(chips[chips.size()-1], vecs[i].gap);
            check($sformatf("v%0d_lat_vld", i), 64'(frame_vld), 64'(vecs[i].exp_vld));
            if (vecs[i].exp_vld) check($sformatf("v%0d_lat_payload", i), 64'(payload), 64'(d));
            settle();
            check($sformatf("v%0d_sym_cnt", i),  64'(sym_cnt),  64'(vecs[i].exp_sym));
            check($sformatf("v%0d_tail_cnt", i), 64'(tail_cnt), 64'(vecs[i].exp_tail));
            check($sformatf("v%0d_ovr_cnt", i),  64'(ovr_cnt),  64'h0);
            check($sformatf("v%0d_sb_empty", i), 64'(sb.size()), 64'h0);
        end

        // Overrun: hold frame A, drop B, then C loads on the draining edge
        fa = with_crc(40'h0102030405);
        fb = with_crc(40'h1122334455);
        fc = with_crc(40'hCAFEBABE77);
        clear_counts();
        frame_rdy = 1'b0;
        build(fa, 0);
        sb.push_back(fa);
        send_all_but_last(0);
        send_chip(chips[chips.size()-1], 0);
        check("ovr_a_vld",     64'(frame_vld), 64'h1);
        check("ovr_a_payload", 64'(payload),   64'(fa));
        build(fb, 0);
        send_all_but_last(0);
        send_chip(chips[chips.size()-1], 0);
        @(posedge clk);
        #1;
        check("ovr_b_pulse",   64'(ovr_cnt),   64'h1);
        check("ovr_b_vld",     64'(frame_vld), 64'h1);
        check("ovr_b_payload", 64'(payload),   64'(fa));
        build(fc, 0);
        send_all_but_last(0);
        sb.push_back(fc);
        frame_rdy = 1'b1;
        send_chip(chips[chips.size()-1], 0);
        check("ovr_c_vld",     64'(frame_vld), 64'h1);
        check("ovr_c_payload", 64'(payload),   64'(fc));
        settle();
        check("ovr_c_pulses",  64'(ovr_cnt),   64'h1);
        check("ovr_sb_empty",  64'(sb.size()), 64'h0);

        // Asynchronous reset in the middle of a payload
        fd = with_crc(40'h5A5A5A5A5A);
        ff = with_crc(40'h0123456789);
        clear_counts();
        frame_rdy = 1'b0;
        build(fd, 0);
        send_all_but_last(0);
        send_chip(chips[chips.size()-1], 0);
        check("mid_pre_vld", 64'(frame_vld), 64'h1);
        build(ff, 0);
        for (int j = 0; j < 30; j++) send_chip(chips[j], 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld",     64'(frame_vld), 64'h0);
        check("mid_rst_payload", 64'(payload),   64'h0);
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_pulses", 64'(sym_cnt + tail_cnt + ovr_cnt + crc_cnt), 64'h0);
        rst_n = 1'b1;
        frame_rdy = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(ff);
        send_all_but_last(0);
        send_chip(chips[chips.size()-1], 0);
        check("mid_after_vld",     64'(frame_vld), 64'h1);
        check("mid_after_payload", 64'(payload),   64'(ff));
        settle();
        check("mid_after_pulses", 64'(sym_cnt + tail_cnt + ovr_cnt + crc_cnt), 64'h0);
        check("mid_sb_empty",     64'(sb.size()), 64'h0);

`ifdef RX_CRC8_EN
        // CRC check: correct CRC delivered, corrupted CRC dropped with crc_err
        begin
            logic [39:0] good_f;
            logic [39:0] bad_f;
            good_f = with_crc(40'h0102030400);
            bad_f  = {good_f[39:8], good_f[7:0] + 8'h01};
            clear_counts();
            build(good_f, 0);
            sb.push_back(good_f);
            send_all_but_last(0);
            send_chip(chips[chips.size()-1], 0);
            check("crc_good_vld", 64'(frame_vld), 64'h1);
            settle();
            check("crc_good_err", 64'(crc_cnt), 64'h0);
            build(bad_f, 0);
            send_all_but_last(0);
            send_chip(chips[chips.size()-1], 0);
            check("crc_bad_vld", 64'(frame_vld), 64'h0);
            settle();
            check("crc_bad_err",    64'(crc_cnt),  64'h1);
            check("crc_bad_ovr",    64'(ovr_cnt),  64'h0);
            check("crc_sb_empty",   64'(sb.size()), 64'h0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
